// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Elastic pipeline-stage register placed between two RV32 pipeline stages.
//   Carries a data bundle and a control bundle under a valid/ready handshake,
//   with hazard stall/flush and saturating stall/flush performance counters.
//   With SKID=1 a second (skid) entry lets o_ready come from registers only.
//   With SKID=0 the stage is a single register and o_ready is combinational.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_valid      upstream bundle valid
//   o_ready      stage can accept a bundle this cycle
//   i_data       upstream data bundle   [DATA_W]
//   i_ctrl       upstream control bundle [CTRL_W], all-zero is a bubble
//   i_stall      hazard stall, freezes the output side
//   i_flush      hazard clear, discards all contents
//   o_valid      output bundle valid
//   i_ready      downstream accepts
//   o_data       output data, zero when o_valid=0
//   o_ctrl       output control, zero when o_valid=0
//   o_occ        entries held (0..2)
//   o_stall_cnt  cycles with o_valid & i_stall (no flush), saturating
//   o_flush_cnt  flush cycles while occupied, saturating
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 160,
    parameter int unsigned CTRL_W = 17,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [1:0]        o_occ,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    occ_t              r_occ;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_valid;
    logic w_ready;
    logic w_acc_in;
    logic w_acc_out;

    assign w_valid   = (r_occ != OCC_EMPTY);
    assign w_acc_out = w_valid & i_ready & ~i_stall;
    assign w_acc_in  = i_valid & w_ready;

    // SKID=1 ready looks only at occupancy; SKID=0 may accept into the slot
    // being vacated this cycle, hence the combinational acc_out term.
    always_comb begin
        w_ready = 1'b0;
        if (SKID != 0) begin
            w_ready = i_rst_n & (r_occ != OCC_TWO);
        end else begin
            w_ready = i_rst_n & ((r_occ == OCC_EMPTY) | w_acc_out);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_occ       <= OCC_EMPTY;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_valid & i_stall & ~i_flush & (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (i_flush & w_valid & (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end

            if (i_flush) begin
                // Flush wins over stall and drops any same-cycle input.
                r_occ       <= OCC_EMPTY;
                r_main_data <= '0;
                r_main_ctrl <= '0;
                r_skid_data <= '0;
                r_skid_ctrl <= '0;
            end else begin
                case (r_occ)
                    OCC_EMPTY: begin
                        if (w_acc_in) begin
                            r_main_data <= i_data;
                            r_main_ctrl <= i_ctrl;
                            r_occ       <= OCC_ONE;
                        end
                    end
                    OCC_ONE: begin
                        if (w_acc_in & w_acc_out) begin
                            r_main_data <= i_data;
                            r_main_ctrl <= i_ctrl;
                        end else if (w_acc_in && (SKID != 0)) begin
                            r_skid_data <= i_data;
                            r_skid_ctrl <= i_ctrl;
                            r_occ       <= OCC_TWO;
                        end else if (w_acc_out) begin
                            // Zero the main entry so outputs read as a bubble.
                            r_main_data <= '0;
                            r_main_ctrl <= '0;
                            r_occ       <= OCC_EMPTY;
                        end
                    end
                    OCC_TWO: begin
                        if (w_acc_out) begin
                            r_main_data <= r_skid_data;
                            r_main_ctrl <= r_skid_ctrl;
                            r_skid_data <= '0;
                            r_skid_ctrl <= '0;
                            r_occ       <= OCC_ONE;
                        end
                    end
                    default: begin
                        r_occ <= OCC_EMPTY;
                    end
                endcase
            end
        end
    end

    assign o_ready     = w_ready;
    assign o_valid     = w_valid;
    assign o_data      = r_main_data;
    assign o_ctrl      = r_main_ctrl;
    assign o_occ       = r_occ;
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: a SKID=1 instance driven from a vector table
// plus hand-written sequences, and a SKID=0 instance driven by hand.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 17;
    localparam int unsigned NW = 4;

    logic clk;
    logic rst_n;

    // SKID=1 instance signals
    logic          a_valid, a_ordy, a_stall, a_flush, a_ovalid, a_irdy;
    logic [DW-1:0] a_data, a_odata;
    logic [CW-1:0] a_ctrl, a_octrl;
    logic [1:0]    a_occ;
    logic [NW-1:0] a_scnt, a_fcnt;

    // SKID=0 instance signals
    logic          b_valid, b_ordy, b_stall, b_flush, b_ovalid, b_irdy;
    logic [DW-1:0] b_data, b_odata;
    logic [CW-1:0] b_ctrl, b_octrl;
    logic [1:0]    b_occ;
    logic [NW-1:0] b_scnt, b_fcnt;

    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_valid), .o_ready(a_ordy),
        .i_data(a_data), .i_ctrl(a_ctrl), .i_stall(a_stall), .i_flush(a_flush),
        .o_valid(a_ovalid), .i_ready(a_irdy), .o_data(a_odata), .o_ctrl(a_octrl),
        .o_occ(a_occ), .o_stall_cnt(a_scnt), .o_flush_cnt(a_fcnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .o_ready(b_ordy),
        .i_data(b_data), .i_ctrl(b_ctrl), .i_stall(b_stall), .i_flush(b_flush),
        .o_valid(b_ovalid), .i_ready(b_irdy), .o_data(b_odata), .o_ctrl(b_octrl),
        .o_occ(b_occ), .o_stall_cnt(b_scnt), .o_flush_cnt(b_fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          st;
        logic          fl;
        logic          rd;
        logic          e_rdy;   // o_ready before the edge
        logic          e_ov;    // after the edge
        logic [DW-1:0] e_d;
        logic [CW-1:0] e_c;
        logic [1:0]    e_occ;
        logic [NW-1:0] e_scnt;
        logic [NW-1:0] e_fcnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic st, input logic fl, input logic rd,
                       input logic e_rdy, input logic e_ov, input logic [DW-1:0] e_d,
                       input logic [CW-1:0] e_c, input logic [1:0] e_occ,
                       input logic [NW-1:0] e_scnt, input logic [NW-1:0] e_fcnt);
        vec_t t;
        t.v = v; t.d = d; t.c = c; t.st = st; t.fl = fl; t.rd = rd;
        t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_d = e_d; t.e_c = e_c;
        t.e_occ = e_occ; t.e_scnt = e_scnt; t.e_fcnt = e_fcnt;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                           input logic st, input logic fl, input logic rd);
        a_valid = v; a_data = d; a_ctrl = c; a_stall = st; a_flush = fl; a_irdy = rd;
    endtask

    initial begin
        rst_n = 1'b0;
        drive_a(0, '0, '0, 0, 0, 0);
        b_valid = 0; b_data = '0; b_ctrl = '0; b_stall = 0; b_flush = 0; b_irdy = 0;

        //  v  d       c        st fl rd | rdy ov e_d     e_c      occ scnt fcnt
        // streaming
        add(1, 32'h1,  17'h1,   0, 0, 1,   1,  1, 32'h1,  17'h1,   1,  0,   0);
        add(1, 32'h2,  17'h2,   0, 0, 1,   1,  1, 32'h2,  17'h2,   1,  0,   0);
        add(1, 32'h3,  17'h3,   0, 0, 1,   1,  1, 32'h3,  17'h3,   1,  0,   0);
        // backpressure: A, B into skid, C held upstream, then drain in order
        add(1, 32'hA,  17'hA,   0, 0, 1,   1,  1, 32'hA,  17'hA,   1,  0,   0);
        add(1, 32'hB,  17'hB,   0, 0, 0,   1,  1, 32'hA,  17'hA,   2,  0,   0);
        add(1, 32'hC,  17'hC,   0, 0, 0,   0,  1, 32'hA,  17'hA,   2,  0,   0);
        add(1, 32'hC,  17'hC,   0, 0, 1,   0,  1, 32'hB,  17'hB,   1,  0,   0);
        add(1, 32'hC,  17'hC,   0, 0, 1,   1,  1, 32'hC,  17'hC,   1,  0,   0);
        add(0, 32'h0,  17'h0,   0, 0, 1,   1,  0, 32'h0,  17'h0,   0,  0,   0);
        // stall hold, then stall+flush
        add(1, 32'h55, 17'h1ABCD,0,0, 1,   1,  1, 32'h55, 17'h1ABCD,1, 0,   0);
        add(0, 32'h0,  17'h0,   1, 0, 1,   1,  1, 32'h55, 17'h1ABCD,1, 1,   0);
        add(0, 32'h0,  17'h0,   1, 0, 1,   1,  1, 32'h55, 17'h1ABCD,1, 2,   0);
        add(0, 32'h0,  17'h0,   1, 0, 1,   1,  1, 32'h55, 17'h1ABCD,1, 3,   0);
        add(0, 32'h0,  17'h0,   1, 1, 1,   1,  0, 32'h0,  17'h0,   0,  3,   1);
        // flush drops a same-cycle input; empty flush is not counted
        add(1, 32'h77, 17'h77,  0, 1, 1,   1,  0, 32'h0,  17'h0,   0,  3,   1);
        add(0, 32'h0,  17'h0,   0, 0, 1,   1,  0, 32'h0,  17'h0,   0,  3,   1);
        // flush with occ=2, then next bundle appears one cycle after acceptance
        add(1, 32'h10, 17'h10,  0, 0, 0,   1,  1, 32'h10, 17'h10,  1,  3,   1);
        add(1, 32'h11, 17'h11,  0, 0, 0,   1,  1, 32'h10, 17'h10,  2,  3,   1);
        add(1, 32'h12, 17'h12,  0, 1, 0,   0,  0, 32'h0,  17'h0,   0,  3,   2);
        add(1, 32'h13, 17'h13,  0, 0, 1,   1,  1, 32'h13, 17'h13,  1,  3,   2);
        add(0, 32'h0,  17'h0,   0, 0, 1,   1,  0, 32'h0,  17'h0,   0,  3,   2);
        // inputs still accepted into free entries during stall
        add(1, 32'h20, 17'h20,  1, 0, 1,   1,  1, 32'h20, 17'h20,  1,  3,   2);
        add(1, 32'h21, 17'h21,  1, 0, 1,   1,  1, 32'h20, 17'h20,  2,  4,   2);
        add(1, 32'h22, 17'h22,  1, 0, 1,   0,  1, 32'h20, 17'h20,  2,  5,   2);
        add(0, 32'h0,  17'h0,   0, 0, 1,   0,  1, 32'h21, 17'h21,  1,  5,   2);
        add(0, 32'h0,  17'h0,   0, 0, 1,   1,  0, 32'h0,  17'h0,   0,  5,   2);

        // reset
        #1;
        chk("rst_ready_low", a_ordy, 0);
        tick();
        tick();
        chk("rst_valid", a_ovalid, 0);
        chk("rst_data", a_odata, 0);
        chk("rst_ctrl", a_octrl, 0);
        chk("rst_occ", a_occ, 0);
        chk("rst_scnt", a_scnt, 0);
        chk("rst_fcnt", a_fcnt, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", a_ordy, 1);
        chk("rel_ready0", b_ordy, 1);

        // table
        foreach (vecs[i]) begin
            drive_a(vecs[i].v, vecs[i].d, vecs[i].c, vecs[i].st, vecs[i].fl, vecs[i].rd);
            #1;
            chk($sformatf("v%0d_ready", i), a_ordy, vecs[i].e_rdy);
            tick();
            chk($sformatf("v%0d_valid", i), a_ovalid, vecs[i].e_ov);
            chk($sformatf("v%0d_data", i), a_odata, vecs[i].e_d);
            chk($sformatf("v%0d_ctrl", i), a_octrl, vecs[i].e_c);
            chk($sformatf("v%0d_occ", i), a_occ, vecs[i].e_occ);
            chk($sformatf("v%0d_scnt", i), a_scnt, vecs[i].e_scnt);
            chk($sformatf("v%0d_fcnt", i), a_fcnt, vecs[i].e_fcnt);
        end
        drive_a(0, '0, '0, 0, 0, 1);

        // SKID=0: combinational ready, never more than one entry
        b_valid = 1; b_data = 32'h1; b_ctrl = 17'h1; b_irdy = 1;
        #1; chk("s0_ready_empty", b_ordy, 1);
        tick();
        chk("s0_out1", b_odata, 32'h1);
        chk("s0_occ1", b_occ, 1);
        b_data = 32'h2; b_ctrl = 17'h2;
        #1; chk("s0_ready_thru", b_ordy, 1);
        b_irdy = 0;
        #1; chk("s0_ready_drop", b_ordy, 0);
        tick();
        chk("s0_hold_a", b_odata, 32'h1);
        chk("s0_occ_a", b_occ, 1);
        tick();
        chk("s0_hold_b", b_odata, 32'h1);
        chk("s0_occ_b", b_occ, 1);
        b_irdy = 1;
        #1; chk("s0_ready_back", b_ordy, 1);
        tick();
        chk("s0_out2", b_odata, 32'h2);
        chk("s0_ctrl2", b_octrl, 17'h2);
        chk("s0_occ2", b_occ, 1);
        b_valid = 0; b_stall = 1;
        #1; chk("s0_ready_stall", b_ordy, 0);
        tick();
        chk("s0_stall_hold", b_odata, 32'h2);
        chk("s0_scnt", b_scnt, 1);
        b_stall = 0; b_flush = 1;
        tick();
        chk("s0_flush_valid", b_ovalid, 0);
        chk("s0_flush_data", b_odata, 0);
        chk("s0_fcnt", b_fcnt, 1);
        b_flush = 0;

        // stall counter saturation
        drive_a(1, 32'h30, 17'h30, 0, 0, 1);
        tick();
        chk("sat_load", a_odata, 32'h30);
        drive_a(0, '0, '0, 1, 0, 1);
        for (int k = 0; k < 20; k++) tick();
        chk("sat_scnt", a_scnt, 15);
        chk("sat_hold", a_odata, 32'h30);

        // reset while holding two entries
        drive_a(1, 32'h31, 17'h31, 0, 0, 0);
        tick();
        chk("pre_rst_occ", a_occ, 2);
        drive_a(0, '0, '0, 0, 0, 1);
        rst_n = 1'b0;
        #1; chk("in_rst_ready", a_ordy, 0);
        tick();
        chk("mrst_valid", a_ovalid, 0);
        chk("mrst_data", a_odata, 0);
        chk("mrst_ctrl", a_octrl, 0);
        chk("mrst_occ", a_occ, 0);
        chk("mrst_scnt", a_scnt, 0);
        chk("mrst_fcnt", a_fcnt, 0);
        chk("mrst_ready", a_ordy, 0);
        rst_n = 1'b1;
        drive_a(1, 32'h40, 17'h40, 0, 0, 1);
        #1; chk("mrel_ready", a_ordy, 1);
        tick();
        chk("post_rst_data", a_odata, 32'h40);
        chk("post_rst_valid", a_ovalid, 1);
        drive_a(0, '0, '0, 0, 0, 1);
        tick();
        chk("post_rst_empty", a_occ, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
